// File: rtl/morph_frame_ctrl_if.sv
// Control/status bundle between the video stream, software config and morph_frame_ctrl.
// The stream side (vsync/href/clken) is shared with the morphology engine input.
interface morph_frame_ctrl_if;
    logic        cfg_wr;
    logic [1:0]  cfg_mode;
    logic        err_clr;
    logic        in_vsync;
    logic        in_href;
    logic        in_clken;
    logic [1:0]  active_mode;
    logic        cfg_pending;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        pix_err;
    logic        line_err;

    modport master (
        output cfg_wr, cfg_mode, err_clr, in_vsync, in_href, in_clken,
        input  active_mode, cfg_pending, busy, frame_done, frame_cnt, pix_err, line_err
    );

    modport slave (
        input  cfg_wr, cfg_mode, err_clr, in_vsync, in_href, in_clken,
        output active_mode, cfg_pending, busy, frame_done, frame_cnt, pix_err, line_err
    );
endinterface

// File: rtl/morph_frame_ctrl.sv
// Frame-level controller for the 3x3 binary morphology engine: shadowed mode register
// applied only at frame start, frame geometry checking, frame counting and drain tracking.
module morph_frame_ctrl #(
    parameter logic [9:0] IMG_HDISP = 10'd320,
    parameter logic [9:0] IMG_VDISP = 10'd240,
    parameter logic [7:0] DRAIN_CYC = 8'd16
) (
    input  logic               clk,
    input  logic               rst,
    morph_frame_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        vsync_d;
    logic        href_d;
    logic        vs_rise;
    logic        vs_fall;
    logic        hr_fall;

    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic [9:0]  vcnt_inc;
    logic [9:0]  vcnt_at_end;
    logic [7:0]  drain_cnt;
    logic        drain_last;

    logic [1:0]  shadow;
    logic [1:0]  active_mode_q;
    logic        cfg_pending_q;
    logic        busy_q;
    logic        frame_done_q;
    logic [15:0] frame_cnt_q;
    logic        pix_err_q;
    logic        line_err_q;

    logic        frame_start;
    logic        pix_en;
    logic        line_end;
    logic        frame_end;
    logic        drain_done;
    logic        pix_bad;
    logic        line_bad;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    // Reserved encoding falls back to bypass so the engine never sees an undefined op.
    function automatic logic [1:0] map_mode(input logic [1:0] m);
        return (m == 2'd3) ? 2'd0 : m;
    endfunction

    // vsync_d/href_d reset high so a frame already in flight at reset release is skipped.
    assign vs_rise    = bus.in_vsync & ~vsync_d;
    assign vs_fall    = ~bus.in_vsync & vsync_d;
    assign hr_fall    = ~bus.in_href & href_d;
    assign drain_last = (drain_cnt <= 8'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (vs_rise) state_nxt = FRAME;
            FRAME:   if (vs_fall) state_nxt = DRAIN;
            DRAIN: begin
                if (vs_rise)         state_nxt = FRAME;
                else if (drain_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        frame_start = 1'b0;
        pix_en      = 1'b0;
        line_end    = 1'b0;
        frame_end   = 1'b0;
        drain_done  = 1'b0;
        case (state)
            IDLE:  frame_start = vs_rise;
            FRAME: begin
                pix_en    = bus.in_href & bus.in_clken;
                line_end  = hr_fall;
                frame_end = vs_fall;
            end
            DRAIN: begin
                frame_start = vs_rise;
                drain_done  = vs_rise | drain_last;
            end
            default: ;
        endcase
    end

    // A line closing on the same clock as the frame counts before the line total is checked.
    assign vcnt_inc    = sat_inc10(vcnt);
    assign vcnt_at_end = line_end ? vcnt_inc : vcnt;
    assign pix_bad     = line_end & (hcnt != IMG_HDISP);
    assign line_bad    = frame_end & (vcnt_at_end != IMG_VDISP);

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d       <= 1'b1;
            href_d        <= 1'b1;
            shadow        <= 2'd0;
            cfg_pending_q <= 1'b0;
            active_mode_q <= 2'd0;
            hcnt          <= 10'd0;
            vcnt          <= 10'd0;
            drain_cnt     <= 8'd0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= 16'd0;
            pix_err_q     <= 1'b0;
            line_err_q    <= 1'b0;
        end else begin
            vsync_d <= bus.in_vsync;
            href_d  <= bus.in_href;

            // A write landing on the apply clock is kept for the following frame.
            if (bus.cfg_wr) begin
                shadow <= bus.cfg_mode;
            end
            if (bus.cfg_wr) begin
                cfg_pending_q <= 1'b1;
            end else if (frame_start) begin
                cfg_pending_q <= 1'b0;
            end
            if (frame_start) begin
                active_mode_q <= map_mode(shadow);
            end

            if (frame_start) begin
                hcnt <= 10'd0;
                vcnt <= 10'd0;
            end else if (line_end) begin
                hcnt <= 10'd0;
                vcnt <= vcnt_inc;
            end else if (pix_en) begin
                hcnt <= sat_inc10(hcnt);
            end

            if (frame_end) begin
                drain_cnt <= DRAIN_CYC;
            end else if (drain_done) begin
                drain_cnt <= 8'd0;
            end else if (state == DRAIN) begin
                drain_cnt <= drain_cnt - 8'd1;
            end

            busy_q       <= (state_nxt != IDLE);
            frame_done_q <= drain_done;
            if (drain_done) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end

            // A fresh error outranks a clear arriving on the same clock.
            if (pix_bad) begin
                pix_err_q <= 1'b1;
            end else if (bus.err_clr) begin
                pix_err_q <= 1'b0;
            end
            if (line_bad) begin
                line_err_q <= 1'b1;
            end else if (bus.err_clr) begin
                line_err_q <= 1'b0;
            end
        end
    end

    assign bus.active_mode = active_mode_q;
    assign bus.cfg_pending = cfg_pending_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.pix_err     = pix_err_q;
    assign bus.line_err    = line_err_q;

endmodule

// File: tb/tb_morph_frame_ctrl.sv
// Directed bench for morph_frame_ctrl: two instances (drain 3 and drain 5) share one stimulus
// stream; a frame table drives the main cases, hand sequences cover reset and drain cut-short.
module tb_morph_frame_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    morph_frame_ctrl_if bus_a ();
    morph_frame_ctrl_if bus_b ();

    assign bus_b.cfg_wr   = bus_a.cfg_wr;
    assign bus_b.cfg_mode = bus_a.cfg_mode;
    assign bus_b.err_clr  = bus_a.err_clr;
    assign bus_b.in_vsync = bus_a.in_vsync;
    assign bus_b.in_href  = bus_a.in_href;
    assign bus_b.in_clken = bus_a.in_clken;

    morph_frame_ctrl #(.IMG_HDISP(10'd8), .IMG_VDISP(10'd4), .DRAIN_CYC(8'd3)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    morph_frame_ctrl #(.IMG_HDISP(10'd8), .IMG_VDISP(10'd4), .DRAIN_CYC(8'd5)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    typedef struct {
        int          lines;
        int          pix0;
        int          pix;
        bit          wr_rise;
        bit          wr_mid;
        logic [1:0]  wmode;
        bit          clr_before;
        bit          clr_l0;
        logic [1:0]  exp_mode;
        bit          exp_pend;
        bit          exp_pix;
        bit          exp_line;
        logic [15:0] exp_cnt;
    } frame_t;

    frame_t tbl[8];
    frame_t one;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lines(input int nl, input int np);
        for (int l = 0; l < nl; l++) begin
            bus_a.in_href  = 1'b1;
            bus_a.in_clken = 1'b1;
            for (int p = 0; p < np; p++) step();
            bus_a.in_href  = 1'b0;
            bus_a.in_clken = 1'b0;
            step();
            step();
        end
    endtask

    // Drop vsync, then wait (bounded) for both drain pulses and check their latency.
    task automatic finish_frame(input logic [15:0] exp_cnt);
        int ka;
        int kb;
        ka = 0;
        kb = 0;
        bus_a.in_vsync = 1'b0;
        step();
        for (int k = 1; k <= 20 && (ka == 0 || kb == 0); k++) begin
            step();
            if (ka == 0 && bus_a.frame_done) ka = k;
            if (kb == 0 && bus_b.frame_done) kb = k;
        end
        check("drain_lat_a", ka, 3);
        check("drain_lat_b", kb, 5);
        check("idle_busy_a", bus_a.busy, 0);
        check("idle_busy_b", bus_b.busy, 0);
        check("frame_cnt_a", bus_a.frame_cnt, exp_cnt);
        check("frame_cnt_b", bus_b.frame_cnt, exp_cnt);
    endtask

    task automatic run_frame(input frame_t f);
        if (f.clr_before) begin
            bus_a.err_clr = 1'b1;
            step();
            bus_a.err_clr = 1'b0;
            check("clr_pix_err", bus_a.pix_err, 0);
            check("clr_line_err", bus_a.line_err, 0);
        end
        bus_a.in_vsync = 1'b1;
        if (f.wr_rise) begin
            bus_a.cfg_wr   = 1'b1;
            bus_a.cfg_mode = f.wmode;
        end
        step();
        bus_a.cfg_wr = 1'b0;
        check("busy_start", bus_a.busy, 1);
        check("mode_start", bus_a.active_mode, f.exp_mode);
        check("pend_start", bus_a.cfg_pending, f.wr_rise);
        step();
        step();
        for (int l = 0; l < f.lines; l++) begin
            int n;
            n = (l == 0) ? f.pix0 : f.pix;
            bus_a.in_href  = 1'b1;
            bus_a.in_clken = 1'b1;
            for (int p = 0; p < n; p++) begin
                if (f.wr_mid && l == 1 && p == 0) begin
                    bus_a.cfg_wr   = 1'b1;
                    bus_a.cfg_mode = f.wmode;
                end
                step();
                bus_a.cfg_wr = 1'b0;
                if (f.wr_mid && l == 1 && p == 0) begin
                    check("pend_mid", bus_a.cfg_pending, 1);
                    check("mode_mid", bus_a.active_mode, f.exp_mode);
                end
            end
            bus_a.in_href  = 1'b0;
            bus_a.in_clken = 1'b0;
            if (f.clr_l0 && l == 0) bus_a.err_clr = 1'b1;
            step();
            bus_a.err_clr = 1'b0;
            if (f.clr_l0 && l == 0) check("clr_vs_new_err", bus_a.pix_err, 1);
            step();
        end
        finish_frame(f.exp_cnt);
        check("mode_end", bus_a.active_mode, f.exp_mode);
        check("pend_end", bus_a.cfg_pending, f.exp_pend);
        check("pix_err", bus_a.pix_err, f.exp_pix);
        check("line_err", bus_a.line_err, f.exp_line);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // lines pix0 pix wr_rise wr_mid wmode clr_before clr_l0 exp_mode pend pix line cnt
        tbl[0] = '{4, 8, 8, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd1};
        tbl[1] = '{4, 8, 8, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 16'd2};
        tbl[2] = '{4, 8, 8, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 16'd3};
        tbl[3] = '{4, 8, 8, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd4};
        tbl[4] = '{3, 7, 8, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 16'd5};
        tbl[5] = '{4, 7, 8, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 16'd6};
        tbl[6] = '{4, 8, 8, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 16'd7};
        tbl[7] = '{4, 8, 8, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'd8};

        rst            = 1'b1;
        bus_a.cfg_wr   = 1'b0;
        bus_a.cfg_mode = 2'd0;
        bus_a.err_clr  = 1'b0;
        bus_a.in_vsync = 1'b0;
        bus_a.in_href  = 1'b0;
        bus_a.in_clken = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        check("rst_mode", bus_a.active_mode, 0);
        check("rst_pend", bus_a.cfg_pending, 0);
        check("rst_busy", bus_a.busy, 0);
        check("rst_done", bus_a.frame_done, 0);
        check("rst_cnt", bus_a.frame_cnt, 0);
        check("rst_pix_err", bus_a.pix_err, 0);
        check("rst_line_err", bus_a.line_err, 0);

        for (int i = 0; i < 8; i++) run_frame(tbl[i]);

        // Reset in the middle of a frame with vsync held high.
        bus_a.in_vsync = 1'b1;
        step();
        bus_a.in_href  = 1'b1;
        bus_a.in_clken = 1'b1;
        bus_a.cfg_wr   = 1'b1;
        bus_a.cfg_mode = 2'd1;
        step();
        bus_a.cfg_wr = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("mrst_mode", bus_a.active_mode, 0);
        check("mrst_pend", bus_a.cfg_pending, 0);
        check("mrst_busy", bus_a.busy, 0);
        check("mrst_cnt", bus_a.frame_cnt, 0);
        check("mrst_busy_b", bus_b.busy, 0);
        lines(2, 8);
        check("mrst_busy_held", bus_a.busy, 0);
        bus_a.in_vsync = 1'b0;
        step();
        check("mrst_busy_fall", bus_a.busy, 0);
        one = '{4, 8, 8, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'd1};
        run_frame(one);

        // vsync re-rises one clock after falling: drain is cut short on both instances.
        bus_a.in_vsync = 1'b1;
        step();
        step();
        lines(4, 8);
        bus_a.in_vsync = 1'b0;
        bus_a.cfg_wr   = 1'b1;
        bus_a.cfg_mode = 2'd1;
        step();
        bus_a.cfg_wr   = 1'b0;
        bus_a.in_vsync = 1'b1;
        step();
        check("cut_done_a", bus_a.frame_done, 1);
        check("cut_done_b", bus_b.frame_done, 1);
        check("cut_cnt_a", bus_a.frame_cnt, 2);
        check("cut_cnt_b", bus_b.frame_cnt, 2);
        check("cut_busy_b", bus_b.busy, 1);
        check("cut_mode_b", bus_b.active_mode, 1);
        check("cut_pend_b", bus_b.cfg_pending, 0);
        step();
        check("cut_pulse_b", bus_b.frame_done, 0);
        check("cut_busy2_b", bus_b.busy, 1);
        step();
        lines(4, 8);
        finish_frame(16'd3);
        check("cut_lerr_b", bus_b.line_err, 0);

        // Frame counter wrap from 0xFFFF.
        force dut_a.frame_cnt_q = 16'hFFFF;
        force dut_b.frame_cnt_q = 16'hFFFF;
        step();
        release dut_a.frame_cnt_q;
        release dut_b.frame_cnt_q;
        step();
        check("preset_cnt", bus_a.frame_cnt, 16'hFFFF);
        one = '{4, 8, 8, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'd0};
        run_frame(one);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/morph_frame_ctrl.md
Name: morph_frame_ctrl

Overview:
Frame-level controller for the binary 3x3 morphology engine in the video pipeline. It sits alongside the engine, on the same clk/vsync/href/clken stream as the engine input. It holds a shadowed mode register (bypass / erode / dilate) that software writes at any time. The register is applied only at a frame start, so the engine never changes operation mid-frame. The block also checks frame geometry, counts frames, and reports frame completion once the engine pipeline has drained.

Parameters:
IMG_HDISP, 10'd320, expected active pixels per line
IMG_VDISP, 10'd240, expected active lines per frame
DRAIN_CYC, 8'd16, clocks to wait after vsync falls before declaring the frame done (covers engine latency)

Ports:
clk  in  1  pixel clock; the only clock
rst  in  1  synchronous, active-high reset
cfg_wr  in  1  one-cycle write strobe for cfg_mode
cfg_mode  in  2  requested mode: 0 bypass, 1 erode, 2 dilate, 3 reserved (treated as bypass)
err_clr  in  1  one-cycle clear of the sticky error flags
in_vsync  in  1  frame valid, high for the whole frame
in_href  in  1  line valid
in_clken  in  1  pixel enable
active_mode  out  2  mode currently driving the engine/output mux
cfg_pending  out  1  shadow written but not yet applied
busy  out  1  high in FRAME and DRAIN
frame_done  out  1  one-cycle pulse at end of drain
frame_cnt  out  16  completed frames, wraps 0xFFFF->0
pix_err  out  1  sticky: some line's pixel count != IMG_HDISP
line_err  out  1  sticky: some frame's line count != IMG_VDISP

Behaviour:
- All logic is on posedge clk. rst is synchronous and active-high; no other reset exists.
- Reset values:
  - active_mode=0, shadow=0, cfg_pending=0, busy=0, frame_done=0, frame_cnt=0, pix_err=0, line_err=0.
  - State=IDLE, hcnt=0, vcnt=0, drain counter=0.
  - vsync_d=1 and href_d=1.
- Edge detection uses in_vsync/in_href registered one clock:
  - vs_rise = in_vsync & ~vsync_d; vs_fall = ~in_vsync & vsync_d.
  - hr_fall = ~in_href & href_d.
- Because vsync_d resets to 1, a frame already in progress at reset release is ignored. Control waits for the next vs_rise.
- Config handling:
  - cfg_wr loads the shadow and sets cfg_pending=1. The last write before apply wins.
  - Apply means: active_mode<=shadow (3 maps to 0) and cfg_pending<=0. Apply happens only on the vs_rise that starts a frame.
  - If cfg_wr and the apply occur in the same cycle, the write is not applied. The new shadow is stored and cfg_pending stays 1.
- State machine:
  - IDLE: on vs_rise -> FRAME. Apply config, clear hcnt/vcnt.
  - FRAME: each cycle with in_href & in_clken, hcnt+1 (saturates at 1023).
    - On hr_fall: set pix_err if hcnt!=IMG_HDISP, then clear hcnt and increment vcnt (saturates at 1023).
    - On vs_fall: set line_err if vcnt!=IMG_VDISP, load the drain counter with DRAIN_CYC, -> DRAIN.
  - DRAIN: decrement the counter each clock. When it reaches 1: frame_done=1 for one clock, frame_cnt+1, -> IDLE.
    - DRAIN_CYC=0 behaves as 1.
    - If vs_rise occurs in DRAIN, drain is cut short: frame_done pulses and frame_cnt increments in that cycle. The machine goes straight to FRAME with config applied and counters cleared.
- busy=1 in FRAME and DRAIN.
- hr_fall coinciding with vs_fall: the line check and vcnt increment are performed first, then the line_err check uses the incremented vcnt.
- err_clr clears both sticky flags. If a new error is detected in the same cycle, that error wins and the flag stays set.
- All outputs are registered.
- active_mode is stable from one frame start to the next. The engine output mux selects on active_mode.

Test Plan:
- IMG_HDISP=8, IMG_VDISP=4, DRAIN_CYC=3. Frame of 4 lines x 8 clken pixels.
  - Expect busy high from the cycle after vs_rise; frame_done exactly 3 clocks after vs_fall; frame_cnt 0->1; pix_err=line_err=0.
- cfg_wr mode=1 mid-frame.
  - Expect active_mode stays 0 and cfg_pending=1 until the next vs_rise. Then active_mode=1 and cfg_pending=0.
  - Writing mode=3 then yields active_mode=0.
- cfg_wr mode=2 on the exact vs_rise cycle.
  - Expect active_mode unchanged for that frame and cfg_pending=1. Applied at the following frame.
- One line with 7 pixels, and a frame with 3 lines.
  - Expect pix_err=1 and line_err=1.
  - err_clr clears both. err_clr coincident with a fresh bad line leaves pix_err=1.
- Assert rst while in_vsync=1 mid-frame.
  - Expect all outputs 0 and no busy until vsync falls and rises again.
- vs_rise arrives 1 clock after vs_fall with DRAIN_CYC=5.
  - Expect frame_done pulse in that cycle, frame_cnt+1, and immediate FRAME entry.
  - Preset frame_cnt=0xFFFF by running 65535 frames (or force) -> next frame wraps to 0.
